// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// Holds the scan FSM states, the default code width and the decode function.
package decoder_pkg;

  localparam int DEC_IN_W      = 4;
  localparam int DEC_MAX_IN_W  = 8;
  localparam int DEC_MAX_OUT_W = 2**DEC_MAX_IN_W;

  typedef enum logic {
    DEC_IDLE,
    DEC_SCAN
  } dec_state_e;

  // Decoded at the widest supported size; callers truncate to their OUT_W.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot(
    input logic [DEC_MAX_IN_W-1:0] code,
    input logic                    en
  );
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  endfunction

endpackage

// File: rtl/dec_out_stage.sv
// Single-entry valid/ready output register for the decoder.
// Loads when empty or when the held beat is being accepted.
module dec_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_load,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_load) begin
      r_valid <= i_push;
      if (i_push) r_data <= i_data;
    end
  end

endmodule

// File: rtl/decoder_onehot_reg.sv
// Registered binary-to-one-hot decoder with valid/ready output.
// Optional walking-one scan mode is compiled in with DEC_SCAN_EN.
module decoder_onehot_reg
  import decoder_pkg::*;
#(
  parameter  int IN_W     = DEC_IN_W,
  parameter  int SCAN_GAP = 0,
  localparam int OUT_W    = 2**IN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_code,
  input  logic            enable,
  input  logic            scan_start,
  input  logic            scan_stop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUT_W-1:0] out,
  output logic [IN_W-1:0] out_code,
  output logic            scan_active
);

  localparam int DW = OUT_W + IN_W;

  logic          w_load;
  logic          w_acc;
  logic          w_push;
  logic [DW-1:0] w_data;
  logic [DW-1:0] w_q;
  logic [OUT_W-1:0] w_req_oh;

  assign w_req_oh = OUT_W'(onehot(DEC_MAX_IN_W'(in_code), enable));

`ifdef DEC_SCAN_EN
  localparam int GW = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;

  dec_state_e       r_state, w_state_nx;
  logic [IN_W-1:0]  r_idx, w_idx_nx;
  logic [GW-1:0]    r_gap, w_gap_nx;
  logic             w_beat;
  logic [OUT_W-1:0] w_scan_oh;

  assign w_scan_oh = OUT_W'(onehot(DEC_MAX_IN_W'(r_idx), 1'b1));

  assign in_ready    = (r_state == DEC_IDLE) && !scan_start && w_load;
  assign scan_active = (r_state == DEC_SCAN);

  assign w_beat = (r_state == DEC_SCAN) && (r_gap == '0)
               && w_load && !scan_stop;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_gap_nx   = r_gap;
    unique case (r_state)
      DEC_IDLE: begin
        if (scan_start) begin
          w_state_nx = DEC_SCAN;
          w_idx_nx   = '0;
          w_gap_nx   = '0;
        end
      end
      DEC_SCAN: begin
        if (scan_stop) begin
          w_state_nx = DEC_IDLE;
        end else if (w_beat) begin
          w_idx_nx = r_idx + IN_W'(1);
          w_gap_nx = GW'(SCAN_GAP);
          if (r_idx == IN_W'(OUT_W - 1)) w_state_nx = DEC_IDLE;
        end else if (r_gap != '0) begin
          w_gap_nx = r_gap - GW'(1);
        end
      end
      default: w_state_nx = DEC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DEC_IDLE;
      r_idx   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_gap   <= w_gap_nx;
    end
  end

  assign w_push = w_acc || w_beat;
  assign w_data = w_beat ? {w_scan_oh, r_idx}
                         : {w_req_oh, in_code};
`else
  logic w_unused_scan;

  assign w_unused_scan = scan_start ^ scan_stop;
  assign in_ready      = w_load;
  assign scan_active   = 1'b0;
  assign w_push        = w_acc;
  assign w_data        = {w_req_oh, in_code};
`endif

  assign w_acc = in_valid && in_ready;

  dec_out_stage #(
    .W (DW)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_data),
    .i_ready (out_ready),
    .o_load  (w_load),
    .o_valid (out_valid),
    .o_data  (w_q)
  );

  assign out      = w_q[DW-1:IN_W];
  assign out_code = w_q[IN_W-1:0];

endmodule
